// File: rtl/dds_multichannel.sv
// dds_multichannel
// ----------------
// Multi-channel direct digital synthesiser. CHANNELS phase accumulators share
// one sample-rate prescaler. Each channel has a tuning word, a phase offset and
// a waveform mode. Writes land in shadow registers, and every sample tick copies
// all shadows into the active set at once. Samples are registered and are
// qualified by Tick_o.
//
// Ports:
//   Clock        system clock
//   Reset        asynchronous, active-low reset
//   Write_i      single-cycle write strobe
//   Address_i    target channel index (writes to channels >= CHANNELS are dropped)
//   Select_i     0 = tuning word, 1 = phase offset, 2 = mode, 3 = reserved (dropped)
//   Data_i       write data; a mode write uses Data_i[1:0]
//   PhaseSync_i  synchronous clear of every accumulator and of the prescaler;
//                it also commits the shadows and forces a sample update
//   Ack_o        one-cycle pulse in the cycle after an accepted write
//   Tick_o       one-cycle pulse while Signal_o/Msb_o hold freshly updated samples
//   Signal_o     channel n sample at bits [n*OUT_WIDTH +: OUT_WIDTH]
//   Msb_o        per-channel phase MSB (square output), registered with Signal_o
module dds_multichannel #(
    parameter int CHANNELS  = 4,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8,
    parameter int DIVIDER   = 1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Write_i,
    input  logic [3:0]                    Address_i,
    input  logic [1:0]                    Select_i,
    input  logic [ACC_WIDTH-1:0]          Data_i,
    input  logic                          PhaseSync_i,
    output logic                          Ack_o,
    output logic                          Tick_o,
    output logic [CHANNELS*OUT_WIDTH-1:0] Signal_o,
    output logic [CHANNELS-1:0]           Msb_o
);

    typedef enum logic [1:0] {
        MODE_SAW      = 2'd0,
        MODE_SQUARE   = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_OFF      = 2'd3
    } mode_t;

    localparam logic [1:0] SEL_TUNING   = 2'd0;
    localparam logic [1:0] SEL_OFFSET   = 2'd1;
    localparam logic [1:0] SEL_MODE     = 2'd2;
    localparam logic [1:0] SEL_RESERVED = 2'd3;

    localparam int                   CNT_WIDTH = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DIVIDER - 1);

    logic [CNT_WIDTH-1:0] count;
    logic                 tick;
    logic                 update;
    logic                 accept;

    logic [ACC_WIDTH-1:0] acc        [CHANNELS];
    logic [ACC_WIDTH-1:0] acc_next   [CHANNELS];
    logic [ACC_WIDTH-1:0] phase      [CHANNELS];
    logic [ACC_WIDTH-1:0] tw_shadow  [CHANNELS];
    logic [ACC_WIDTH-1:0] tw_active  [CHANNELS];
    logic [ACC_WIDTH-1:0] off_shadow [CHANNELS];
    logic [ACC_WIDTH-1:0] off_active [CHANNELS];
    mode_t                mode_shadow[CHANNELS];
    mode_t                mode_active[CHANNELS];

    logic [OUT_WIDTH-1:0] ph         [CHANNELS];
    logic [OUT_WIDTH-1:0] tri_wave   [CHANNELS];
    logic [OUT_WIDTH-1:0] wave       [CHANNELS];
    logic [CHANNELS-1:0]  ph_msb;

    // A sample update happens on every prescaler tick, and PhaseSync_i forces
    // one as well so the cleared phase shows up immediately.
    assign tick   = (count == CNT_LAST);
    assign update = tick | PhaseSync_i;
    assign accept = Write_i && (int'(Address_i) < CHANNELS) && (Select_i != SEL_RESERVED);

    // Sample-rate prescaler. PhaseSync_i restarts it so that the next regular
    // tick comes a full DIVIDER cycles after the sync.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (PhaseSync_i || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // The acknowledge simply follows an accepted write by one cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Ack_o <= 1'b0;
        end else begin
            Ack_o <= accept;
        end
    end

    // Shadow and active registers. Both are updated by non-blocking
    // assignments on the same edge, so the commit always copies the shadow
    // as it was before that edge. A write that coincides with a tick
    // therefore reaches the active set on the following tick.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                tw_shadow[ch]   <= '0;
                off_shadow[ch]  <= '0;
                mode_shadow[ch] <= MODE_SAW;
                tw_active[ch]   <= '0;
                off_active[ch]  <= '0;
                mode_active[ch] <= MODE_SAW;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (accept && (Address_i == 4'(ch))) begin
                    case (Select_i)
                        SEL_TUNING: tw_shadow[ch]   <= Data_i;
                        SEL_OFFSET: off_shadow[ch]  <= Data_i;
                        SEL_MODE:   mode_shadow[ch] <= mode_t'(Data_i[1:0]);
                        default:    ;
                    endcase
                end
                if (update) begin
                    tw_active[ch]   <= tw_shadow[ch];
                    off_active[ch]  <= off_shadow[ch];
                    mode_active[ch] <= mode_shadow[ch];
                end
            end
        end
    end

    // Next accumulator value and the waveform derived from it. Everything here
    // reads the active set as it stands before the edge's commit, so the
    // tuning word, offset and mode that shape a sample are the ones that were
    // already active when the edge arrived.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            acc_next[ch] = PhaseSync_i ? '0 : acc[ch] + tw_active[ch];
            phase[ch]    = acc_next[ch] + off_active[ch];
            ph[ch]       = OUT_WIDTH'(phase[ch] >> (ACC_WIDTH - OUT_WIDTH));
            ph_msb[ch]   = ph[ch][OUT_WIDTH-1];
            tri_wave[ch] = {ph[ch][OUT_WIDTH-2:0], 1'b0};
            wave[ch]     = '0;
            case (mode_active[ch])
                MODE_SAW:      wave[ch] = ph[ch];
                MODE_SQUARE:   wave[ch] = {OUT_WIDTH{ph_msb[ch]}};
                MODE_TRIANGLE: wave[ch] = ph_msb[ch] ? ~tri_wave[ch] : tri_wave[ch];
                MODE_OFF:      wave[ch] = '0;
                default:       wave[ch] = '0;
            endcase
        end
    end

    // Phase accumulators wrap silently modulo 2^ACC_WIDTH.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc[ch] <= '0;
            end
        end else if (update) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc[ch] <= acc_next[ch];
            end
        end
    end

    // Output sample registers; they hold between updates.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Tick_o   <= 1'b0;
            Signal_o <= '0;
            Msb_o    <= '0;
        end else begin
            Tick_o <= update;
            if (update) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    Signal_o[ch*OUT_WIDTH +: OUT_WIDTH] <= wave[ch];
                end
                Msb_o <= ph_msb;
            end
        end
    end

endmodule
